read_ptr_empty_gray_sync: RTL and testbench
===========================================

// Module: read_ptr_empty_gray_sync
// PURPOSE
//   Read-side pointer and empty controller for the asynchronous FIFO. It is the
//   parametrised successor to the binary read-pointer/empty block.
//   - Gray-coded read pointer for the write domain.
//   - Internal N-flop synchroniser for the incoming write pointer.
//   - Registered empty, almost_empty and fill-count outputs.
//   - Optional sticky underflow flag.
//   Sits in the rclk domain, between the dual-port RAM read address and the
//   write-side full logic.
// PARAMETERS
//   ADDR_W       4  RAM address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits
//   SYNC_STAGES  2  flops in wptr_gray synchroniser chain (>=2)
//   AE_THRESH    2  almost_empty asserted when rd_count <= AE_THRESH
// PORTS
//   rclk          in   1         read clock; all state updates on rising edge
//   r_rst         in   1         asynchronous active-low reset
//   r_en          in   1         read request from consumer
//   wptr_gray     in   ADDR_W+1  Gray write pointer from wclk domain (asynchronous)
//   rptr_gray     out  ADDR_W+1  registered Gray read pointer, to write domain
//   raddr         out  ADDR_W    RAM read address = rbin[ADDR_W-1:0]
//   empty         out  1         registered FIFO-empty flag
//   almost_empty  out  1         registered, rd_count <= AE_THRESH
//   rd_count      out  ADDR_W+1  registered words available (0..2**ADDR_W)
//   underflow     out  1         sticky read-while-empty flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset (r_rst=0, async, no clock needed):
//   - rbin = 0, rptr_gray = 0, all sync flops = 0, rd_count = 0.
//   - empty = 1, almost_empty = 1, underflow = 0.
//   Read handshake:
//   - rd_fire = r_en & ~empty.
//   - r_en while empty is ignored: pointer holds and no RAM address change.
//   Next-state values:
//   - rbin_next = rbin + rd_fire (ADDR_W+1 bits, mod 2**(ADDR_W+1)).
//   - rgray_next = rbin_next ^ (rbin_next >> 1).
//   Synchroniser:
//   - wptr_gray passes through SYNC_STAGES flops to give wptr_sync.
//   - No logic between stages; only stage-1 input is asynchronous.
//   - wbin_sync = gray-to-binary(wptr_sync).
//   Registered updates, all on the same edge from the same next values:
//   - rbin <= rbin_next; rptr_gray <= rgray_next.
//   - empty <= (rgray_next == wptr_sync).
//   - rd_count <= wbin_sync - rbin_next (mod 2**(ADDR_W+1)).
//   - almost_empty <= (wbin_sync - rbin_next) <= AE_THRESH.
//   Latency:
//   - A wptr_gray change is visible on empty/rd_count after SYNC_STAGES+1 rclk edges.
//   - A read shows on raddr/rptr_gray/rd_count 1 edge after the accepting edge.
//   Last word: when the read consumes the final word, empty asserts on the same
//   edge the pointer advances. There is no one-cycle empty=0 glitch.
//   Simultaneous read and synced-write update on one edge: rd_count reflects both.
//   A net-zero change leaves empty unchanged.
//   Wrap-around:
//   - rbin wraps from 2**(ADDR_W+1)-1 to 0.
//   - The Gray sequence stays single-bit-change across the wrap.
//   - rd_count arithmetic is modular, so it stays correct across the wrap.
//   Full FIFO: rd_count = 2**ADDR_W, empty = 0. MSB-differing pointers are never
//   treated as empty.
//   Reset mid-operation: all outputs return to reset values immediately. Pending
//   reads are discarded. Reset release is synchronised to rclk externally.
//   rptr_gray is driven directly from a flop, with no combinational path to the
//   write domain.
// CONFIGURATION
//   RD_UNDERFLOW_DET_EN defined:
//   - underflow <= 1 on any rclk edge with r_en=1 and empty=1.
//   - The flag is sticky and is cleared only by r_rst.
//   RD_UNDERFLOW_DET_EN undefined:
//   - The underflow port is still present, tied to 1'b0.
//   - No underflow flop is inferred.
// TESTING  (ADDR_W=2, SYNC_STAGES=2, AE_THRESH=1 unless noted)
//   1 Reset: hold r_rst=0 with random r_en/wptr_gray -> empty=1, almost_empty=1,
//     rd_count=0, raddr=0, rptr_gray=3'b000, underflow=0.
//   2 One write: wptr_gray 000->001 -> empty=0 and rd_count=1 on 3rd rclk edge.
//     Then one-cycle r_en -> raddr=1, rptr_gray=001, empty=1, rd_count=0 on that edge.
//   3 Fill/drain: wptr_gray=110 (bin 4) -> rd_count=4, almost_empty=0 after 3 edges.
//     Then 4 back-to-back reads -> rd_count 3,2,1,0; almost_empty=1 at rd_count=1;
//     empty=1 at 0.
//   4 Wrap: stream 8 writes/8 reads concurrently -> rptr_gray steps
//     000,001,011,010,110,111,101,100,000 with one bit change per step and no
//     spurious empty.
//   5 Underflow: r_en=1 for 3 cycles while empty -> rptr_gray/raddr unchanged.
//     With RD_UNDERFLOW_DET_EN, underflow=1 and stays 1 until r_rst.
//     Without the macro, underflow stays 0.
//   6 Mid-op reset: rd_count=2 and r_en=1, assert r_rst between edges -> all
//     outputs take reset values before the next rclk edge.
//     After release, the first wptr_gray change is tracked from pointer 0.

Source files
------------

// File: rtl/read_ptr_empty_gray_sync.sv
// Read-side pointer, empty/almost-empty and fill-count controller for an async FIFO (rclk domain).
// Optional sticky underflow flag enabled by defining RD_UNDERFLOW_DET_EN.
module read_ptr_empty_gray_sync #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_THRESH   = 2
) (
    input  logic              rclk,
    input  logic              r_rst,
    input  logic              r_en,
    input  logic [ADDR_W:0]   wptr_gray,
    output logic [ADDR_W:0]   rptr_gray,
    output logic [ADDR_W-1:0] raddr,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_count,
    output logic              underflow
);

    logic [ADDR_W:0] rbin_q;
    logic [ADDR_W:0] sync_q [SYNC_STAGES];
    logic [ADDR_W:0] wptr_sync;
    logic [ADDR_W:0] wbin_sync;
    logic [ADDR_W:0] rbin_next;
    logic [ADDR_W:0] rgray_next;
    logic [ADDR_W:0] count_next;
    logic            rd_fire;

    assign wptr_sync = sync_q[SYNC_STAGES-1];
    assign raddr     = rbin_q[ADDR_W-1:0];

    always_comb begin
        wbin_sync = '0;
        for (int i = 0; i <= int'(ADDR_W); i++) begin
            wbin_sync[i] = ^(wptr_sync >> i);
        end
    end

    always_comb begin
        rd_fire    = r_en & ~empty;
        rbin_next  = rbin_q + {{ADDR_W{1'b0}}, rd_fire};
        rgray_next = rbin_next ^ (rbin_next >> 1);
        // Modular difference stays correct across pointer wrap.
        count_next = wbin_sync - rbin_next;
    end

    always_ff @(posedge rclk or negedge r_rst) begin
        if (!r_rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wptr_gray;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge rclk or negedge r_rst) begin
        if (!r_rst) begin
            rbin_q       <= '0;
            rptr_gray    <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_count     <= '0;
        end else begin
            rbin_q       <= rbin_next;
            rptr_gray    <= rgray_next;
            empty        <= (rgray_next == wptr_sync);
            almost_empty <= (32'(count_next) <= AE_THRESH);
            rd_count     <= count_next;
        end
    end

`ifdef RD_UNDERFLOW_DET_EN
    always_ff @(posedge rclk or negedge r_rst) begin
        if (!r_rst) begin
            underflow <= 1'b0;
        end else if (r_en && empty) begin
            underflow <= 1'b1;
        end
    end
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_read_ptr_empty_gray_sync.sv
// Directed self-checking bench for read_ptr_empty_gray_sync (ADDR_W=2, SYNC_STAGES=2, AE_THRESH=1).
module tb_read_ptr_empty_gray_sync;

    localparam int unsigned ADDR_W = 2;

`ifdef RD_UNDERFLOW_DET_EN
    localparam logic UF_ON = 1'b1;
`else
    localparam logic UF_ON = 1'b0;
`endif

    logic              rclk = 1'b0;
    logic              r_rst = 1'b0;
    logic              r_en = 1'b0;
    logic [ADDR_W:0]   wptr_gray = '0;
    logic [ADDR_W:0]   rptr_gray;
    logic [ADDR_W-1:0] raddr;
    logic              empty;
    logic              almost_empty;
    logic [ADDR_W:0]   rd_count;
    logic              underflow;

    int checks = 0;
    int failures = 0;

    // {empty, almost_empty, rd_count, raddr, rptr_gray, underflow}
    logic [10:0] obs;
    assign obs = {empty, almost_empty, rd_count, raddr, rptr_gray, underflow};

    localparam logic [10:0] RST_OBS = {1'b1, 1'b1, 3'd0, 2'd0, 3'b000, 1'b0};

    read_ptr_empty_gray_sync #(
        .ADDR_W     (2),
        .SYNC_STAGES(2),
        .AE_THRESH  (1)
    ) dut (
        .rclk        (rclk),
        .r_rst       (r_rst),
        .r_en        (r_en),
        .wptr_gray   (wptr_gray),
        .rptr_gray   (rptr_gray),
        .raddr       (raddr),
        .empty       (empty),
        .almost_empty(almost_empty),
        .rd_count    (rd_count),
        .underflow   (underflow)
    );

    always #5 rclk = ~rclk;

    function automatic logic [ADDR_W:0] to_gray(input int unsigned b);
        logic [ADDR_W:0] v;
        v = b[ADDR_W:0];
        return v ^ (v >> 1);
    endfunction

    task automatic edge_sample();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge rclk);
        r_rst = 1'b0;
        r_en = 1'b0;
        wptr_gray = '0;
        @(negedge rclk);
        r_rst = 1'b1;
    endtask

    task automatic test_reset();
        r_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge rclk);
            r_en = 1'($urandom);
            wptr_gray = 3'($urandom);
            edge_sample();
            checks++;
            if (obs !== RST_OBS) begin
                failures++;
                $display("FAIL reset_hold[%0d] got=%b want=%b", i, obs, RST_OBS);
            end
        end
        do_reset();
    endtask

    task automatic test_one_write();
        logic [10:0] exp;
        do_reset();
        @(negedge rclk);
        wptr_gray = 3'b001;
        for (int e = 1; e <= 3; e++) begin
            edge_sample();
            exp = (e < 3) ? RST_OBS : {1'b0, 1'b1, 3'd1, 2'd0, 3'b000, 1'b0};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL one_write_edge%0d got=%b want=%b", e, obs, exp);
            end
        end
        @(negedge rclk);
        r_en = 1'b1;
        edge_sample();
        exp = {1'b1, 1'b1, 3'd0, 2'd1, 3'b001, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL last_word_read got=%b want=%b", obs, exp);
        end
        @(negedge rclk);
        r_en = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic [10:0] exp_tab [4];
        logic [10:0] exp;
        exp_tab[0] = {1'b0, 1'b0, 3'd3, 2'd1, 3'b001, 1'b0};
        exp_tab[1] = {1'b0, 1'b0, 3'd2, 2'd2, 3'b011, 1'b0};
        exp_tab[2] = {1'b0, 1'b1, 3'd1, 2'd3, 3'b010, 1'b0};
        exp_tab[3] = {1'b1, 1'b1, 3'd0, 2'd0, 3'b110, 1'b0};
        do_reset();
        @(negedge rclk);
        wptr_gray = 3'b110;
        for (int e = 1; e <= 3; e++) begin
            edge_sample();
            exp = (e < 3) ? RST_OBS : {1'b0, 1'b0, 3'd4, 2'd0, 3'b000, 1'b0};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL fill_edge%0d got=%b want=%b", e, obs, exp);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge rclk);
            r_en = 1'b1;
            edge_sample();
            checks++;
            if (obs !== exp_tab[k]) begin
                failures++;
                $display("FAIL drain_read%0d got=%b want=%b", k, obs, exp_tab[k]);
            end
        end
        @(negedge rclk);
        r_en = 1'b0;
    endtask

    task automatic test_wrap();
        logic [ADDR_W:0] gray_tab [8];
        logic [ADDR_W:0] prev;
        logic [ADDR_W:0] exp_cnt;
        gray_tab[0] = 3'b001; gray_tab[1] = 3'b011; gray_tab[2] = 3'b010; gray_tab[3] = 3'b110;
        gray_tab[4] = 3'b111; gray_tab[5] = 3'b101; gray_tab[6] = 3'b100; gray_tab[7] = 3'b000;
        do_reset();
        // Preload three words so the two-flop sync lag never lets the stream run dry.
        @(negedge rclk);
        wptr_gray = to_gray(3);
        repeat (3) edge_sample();
        checks++;
        if (rd_count !== 3'd3) begin
            failures++;
            $display("FAIL wrap_preload rd_count got=%0d want=3", rd_count);
        end
        prev = rptr_gray;
        for (int k = 1; k <= 8; k++) begin
            @(negedge rclk);
            wptr_gray = to_gray(3 + k);
            r_en = 1'b1;
            edge_sample();
            exp_cnt = (k == 1) ? 3'd2 : 3'd1;
            checks++;
            if (rptr_gray !== gray_tab[k-1] || $countones(rptr_gray ^ prev) != 1 ||
                empty !== 1'b0 || rd_count !== exp_cnt) begin
                failures++;
                $display("FAIL wrap_step%0d rptr=%b empty=%b cnt=%0d want rptr=%b empty=0 cnt=%0d",
                         k, rptr_gray, empty, rd_count, gray_tab[k-1], exp_cnt);
            end
            prev = rptr_gray;
        end
        @(negedge rclk);
        r_en = 1'b0;
    endtask

    task automatic test_underflow();
        logic [10:0] exp;
        do_reset();
        exp = {1'b1, 1'b1, 3'd0, 2'd0, 3'b000, UF_ON};
        for (int e = 0; e < 5; e++) begin
            @(negedge rclk);
            r_en = (e < 3);
            edge_sample();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL underflow_edge%0d got=%b want=%b", e, obs, exp);
            end
        end
        do_reset();
        #1;
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clear got=%b want=0", underflow);
        end
    endtask

    task automatic test_midop_reset();
        logic [10:0] exp;
        do_reset();
        @(negedge rclk);
        wptr_gray = to_gray(2);
        repeat (3) edge_sample();
        exp = {1'b0, 1'b0, 3'd2, 2'd0, 3'b000, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL midop_prefill got=%b want=%b", obs, exp);
        end
        @(negedge rclk);
        r_en = 1'b1;
        #2;
        r_rst = 1'b0;
        #1;
        checks++;
        if (obs !== RST_OBS) begin
            failures++;
            $display("FAIL midop_async got=%b want=%b", obs, RST_OBS);
        end
        edge_sample();
        checks++;
        if (obs !== RST_OBS) begin
            failures++;
            $display("FAIL midop_hold got=%b want=%b", obs, RST_OBS);
        end
        @(negedge rclk);
        r_en = 1'b0;
        wptr_gray = '0;
        @(negedge rclk);
        r_rst = 1'b1;
        @(negedge rclk);
        wptr_gray = 3'b001;
        for (int e = 1; e <= 3; e++) begin
            edge_sample();
            exp = (e < 3) ? RST_OBS : {1'b0, 1'b1, 3'd1, 2'd0, 3'b000, 1'b0};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL post_reset_edge%0d got=%b want=%b", e, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_write();
        test_fill_drain();
        test_wrap();
        test_underflow();
        test_midop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
